// File: rtl/rv_pkg.sv
// Shared types and default widths for the RVTU downstream-port arbiter.
package rv_pkg;
  localparam int unsigned RV_ADDR_W = 32;
  localparam int unsigned RV_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dfp_arb_state_t;
endpackage

// File: rtl/rvtu_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to ptr.
module rvtu_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic w_id;

  assign w_id   = (req[0] && req[1]) ? ptr : req[1];
  assign gnt_id = w_id;
  assign gnt    = (|req) ? (w_id ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/rvtu_dfp_arb.sv
// Arbitrates two caches' line fill/writeback requests onto one downstream port.
// Grant in IDLE, hold the request through BUSY, pulse completion in RESP.
module rvtu_dfp_arb
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = RV_ADDR_W,
  parameter int unsigned LINE_W = RV_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        c_read,
  input  logic [1:0]        c_write,
  input  logic [ADDR_W-1:0] c_addr  [2],
  input  logic [LINE_W-1:0] c_wdata [2],
  output logic [LINE_W-1:0] c_rdata [2],
  output logic [1:0]        c_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  output logic              busy,
  output logic              gnt_id
);
  dfp_arb_state_t    r_state;
  dfp_arb_state_t    w_state_nxt;
  logic              r_ptr;
  logic              r_gnt_id;
  logic              r_m_read;
  logic              r_m_write;
  logic [ADDR_W-1:0] r_m_addr;
  logic [LINE_W-1:0] r_m_wdata;
  logic [LINE_W-1:0] r_c_rdata [2];
  logic [1:0]        r_c_resp;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_pick_id;

  assign w_req = c_read | c_write;

  rvtu_rr_pick2 u_pick (
    .req    (w_req),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_pick_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_gnt) w_state_nxt = BUSY;
      BUSY:    if (m_resp) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A request with both read and write set is issued as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= 1'b0;
      r_gnt_id  <= 1'b0;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_c_resp  <= '0;
      for (int i = 0; i < 2; i++) r_c_rdata[i] <= '0;
    end else begin
      r_c_resp <= '0;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_gnt_id  <= w_pick_id;
          r_m_addr  <= c_addr[w_pick_id];
          r_m_wdata <= c_wdata[w_pick_id];
          r_m_write <= c_write[w_pick_id];
          r_m_read  <= ~c_write[w_pick_id];
        end
        BUSY: if (m_resp) begin
          r_c_rdata[r_gnt_id] <= m_rdata;
          r_c_resp[r_gnt_id]  <= 1'b1;
          r_m_read            <= 1'b0;
          r_m_write           <= 1'b0;
        end
        RESP: r_ptr <= ~r_gnt_id;
        default: ;
      endcase
    end
  end

  assign c_rdata = r_c_rdata;
  assign c_resp  = r_c_resp;
  assign m_read  = r_m_read;
  assign m_write = r_m_write;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state != IDLE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_rw_chk
    a_rw_excl: assert property (@(posedge clk) disable iff (!rst) !(c_read[gi] && c_write[gi]));
  end
endmodule

// File: tb/tb_rvtu_dfp_arb.sv
// Directed bench for rvtu_dfp_arb: reset, single read, ties, fairness, mid-busy reset, spurious and zero-wait responses.
module tb_rvtu_dfp_arb;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    c_read, c_write;
  logic [AW-1:0] c_addr  [2];
  logic [LW-1:0] c_wdata [2];
  logic [LW-1:0] c_rdata [2];
  logic [1:0]    c_resp;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_rdata;
  logic          m_resp, busy, gnt_id;

  int total = 0;
  int bad   = 0;

  localparam logic [AW-1:0] A0 = 32'h4000_0010;
  localparam logic [AW-1:0] A1 = 32'h8000_0200;
  localparam logic [LW-1:0] D0 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [LW-1:0] D1 = 128'h0BADF00D_55AA55AA_0F0F0F0F_13579BDF;
  localparam logic [LW-1:0] W1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [LW-1:0] W2 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

  always #5 clk = ~clk;

  rvtu_dfp_arb #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_read  (c_read),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_rdata (c_rdata),
    .c_resp  (c_resp),
    .m_read  (m_read),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_resp  (m_resp),
    .busy    (busy),
    .gnt_id  (gnt_id)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; c_read = '0; c_write = '0; m_resp = 1'b0; m_rdata = '0;
    c_addr[0] = '0; c_addr[1] = '0; c_wdata[0] = '0; c_wdata[1] = '0;
    tick(); tick();
    total++;
    if ({busy, m_read, m_write, gnt_id, c_resp} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, m_read, m_write, gnt_id, c_resp});
    end
    total++;
    if (m_addr !== '0 || m_wdata !== '0) begin
      bad++; $display("FAIL reset_mbus: got addr %h wdata %h want 0", m_addr, m_wdata);
    end
    total++;
    if (c_rdata[0] !== '0 || c_rdata[1] !== '0) begin
      bad++; $display("FAIL reset_rdata: got %h / %h want 0", c_rdata[0], c_rdata[1]);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    c_read[0] = 1'b1; c_addr[0] = A0;
    tick();
    total++;
    if ({m_read, m_write, busy, gnt_id} !== 4'b1010 || m_addr !== A0) begin
      bad++; $display("FAIL single_issue: got rd/wr/busy/id %b addr %h want 1010 %h", {m_read, m_write, busy, gnt_id}, m_addr, A0);
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      total++;
      if (m_read !== 1'b1 || m_addr !== A0) begin
        bad++; $display("FAIL single_hold: got rd %b addr %h want 1 %h", m_read, m_addr, A0);
      end
    end
    m_rdata = D0; m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b01 || c_rdata[0] !== D0 || m_read !== 1'b0) begin
      bad++; $display("FAIL single_resp: got resp %b data %h rd %b want 01 %h 0", c_resp, c_rdata[0], m_read, D0);
    end
    c_read[0] = 1'b0;
    tick();
    total++;
    if (c_resp !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL single_idle: got resp %b busy %b want 00 0", c_resp, busy);
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b0; tick(); rst = 1'b1;
    c_read = 2'b01; c_write = 2'b10; c_addr[0] = A0; c_addr[1] = A1; c_wdata[1] = W1;
    tick();
    total++;
    if ({m_read, m_write, gnt_id} !== 3'b100 || m_addr !== A0) begin
      bad++; $display("FAIL sim_first: got rd/wr/id %b addr %h want 100 %h", {m_read, m_write, gnt_id}, m_addr, A0);
    end
    m_rdata = D1; m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b01) begin
      bad++; $display("FAIL sim_resp0: got %b want 01", c_resp);
    end
    c_read[0] = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || c_resp !== 2'b00) begin
      bad++; $display("FAIL sim_gap: got busy %b resp %b want 0 00", busy, c_resp);
    end
    tick();
    total++;
    if ({m_read, m_write, gnt_id} !== 3'b011 || m_addr !== A1 || m_wdata !== W1) begin
      bad++; $display("FAIL sim_second: got rd/wr/id %b addr %h wdata %h want 011 %h %h", {m_read, m_write, gnt_id}, m_addr, m_wdata, A1, W1);
    end
    m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b10 || m_write !== 1'b0) begin
      bad++; $display("FAIL sim_resp1: got resp %b wr %b want 10 0", c_resp, m_write);
    end
    c_write[1] = 1'b0;
    tick();
  endtask

  // Both caches hold requests; the first grant also shows the pointer is back at 0.
  task automatic test_fairness();
    logic          exp_id;
    logic [LW-1:0] d;
    exp_id = 1'b0;
    c_read = 2'b11; c_addr[0] = A0; c_addr[1] = A1;
    for (int k = 0; k < 8; k++) begin
      int waitc;
      waitc = 0;
      while (!(m_read || m_write) && waitc < 20) begin
        tick(); waitc++;
      end
      total++;
      if (waitc != ((k == 0) ? 1 : 2)) begin
        bad++; $display("FAIL fair_gap[%0d]: got %0d cycles want %0d", k, waitc, (k == 0) ? 1 : 2);
      end
      total++;
      if (gnt_id !== exp_id || m_addr !== (exp_id ? A1 : A0)) begin
        bad++; $display("FAIL fair_grant[%0d]: got id %b addr %h want %b %h", k, gnt_id, m_addr, exp_id, exp_id ? A1 : A0);
      end
      for (int j = 0; j < k % 3; j++) tick();
      d = {96'h0, 32'hC0DE_0000 | 32'(k)};
      m_rdata = d; m_resp = 1'b1;
      tick();
      m_resp = 1'b0;
      total++;
      if (c_resp !== (exp_id ? 2'b10 : 2'b01) || c_rdata[exp_id] !== d) begin
        bad++; $display("FAIL fair_resp[%0d]: got resp %b data %h want id %b data %h", k, c_resp, c_rdata[exp_id], exp_id, d);
      end
      exp_id = ~exp_id;
    end
    c_read = 2'b00;
    tick(); tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL fair_end: got busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_busy();
    c_read[0] = 1'b1; c_addr[0] = A0;
    tick();
    tick(); tick();
    rst = 1'b0;
    #1;
    total++;
    if ({busy, m_read, m_write, gnt_id, c_resp} !== 6'b0 || m_addr !== '0 || m_wdata !== '0 || c_rdata[0] !== '0) begin
      bad++; $display("FAIL rst_mid: got ctrl %b addr %h rdata0 %h want all 0", {busy, m_read, m_write, gnt_id, c_resp}, m_addr, c_rdata[0]);
    end
    c_read[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (c_resp !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_resp: got resp %b busy %b want 00 0", c_resp, busy);
    end
    c_read[1] = 1'b1; c_addr[1] = A1;
    tick();
    total++;
    if ({m_read, gnt_id} !== 2'b11 || m_addr !== A1) begin
      bad++; $display("FAIL rst_new_issue: got rd/id %b addr %h want 11 %h", {m_read, gnt_id}, m_addr, A1);
    end
    m_rdata = D1; m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b10 || c_rdata[1] !== D1) begin
      bad++; $display("FAIL rst_new_resp: got resp %b data %h want 10 %h", c_resp, c_rdata[1], D1);
    end
    c_read[1] = 1'b0;
    tick();
  endtask

  task automatic test_spurious();
    m_rdata = '1; m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b00 || busy !== 1'b0 || c_rdata[1] !== D1) begin
      bad++; $display("FAIL spurious: got resp %b busy %b data1 %h want 00 0 %h", c_resp, busy, c_rdata[1], D1);
    end
    tick();
    total++;
    if (busy !== 1'b0 || m_read !== 1'b0 || c_resp !== 2'b00) begin
      bad++; $display("FAIL spurious_after: got busy %b rd %b resp %b want 0 0 00", busy, m_read, c_resp);
    end
  endtask

  task automatic test_zero_wait();
    c_read = 2'b01; c_write = 2'b10; c_addr[0] = A0; c_addr[1] = A1; c_wdata[1] = W2;
    tick();
    total++;
    if ({m_read, m_write, gnt_id} !== 3'b100) begin
      bad++; $display("FAIL zw_first: got rd/wr/id %b want 100", {m_read, m_write, gnt_id});
    end
    m_rdata = D0; m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b01 || m_read !== 1'b0 || c_rdata[0] !== D0) begin
      bad++; $display("FAIL zw_resp0: got resp %b rd %b data %h want 01 0 %h", c_resp, m_read, c_rdata[0], D0);
    end
    c_read[0] = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || m_write !== 1'b0) begin
      bad++; $display("FAIL zw_gap: got busy %b wr %b want 0 0", busy, m_write);
    end
    tick();
    total++;
    if ({m_read, m_write, gnt_id} !== 3'b011 || m_wdata !== W2 || m_addr !== A1) begin
      bad++; $display("FAIL zw_second: got rd/wr/id %b wdata %h addr %h want 011 %h %h", {m_read, m_write, gnt_id}, m_wdata, m_addr, W2, A1);
    end
    m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    total++;
    if (c_resp !== 2'b10) begin
      bad++; $display("FAIL zw_resp1: got %b want 10", c_resp);
    end
    c_write[1] = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_reset_mid_busy();
    test_spurious();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rvtu_dfp_arb.md
RVTU_DFP_ARB -- requirements
Module: rvtu_dfp_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port c_read  input  1 [2]  per-cache line-fill request, held until c_resp.
REQ-006 SHALL have port c_write  input  1 [2]  per-cache writeback request, held until c_resp.
REQ-007 SHALL have port c_addr  input  ADDR_W [2]  line address, stable while the request is high.
REQ-008 SHALL have port c_wdata  input  LINE_W [2]  writeback data, stable while c_write is high.
REQ-009 SHALL have port c_rdata  output  LINE_W [2]  fill data, valid while c_resp is high.
REQ-010 SHALL have port c_resp  output  1 [2]  one-cycle completion pulse to the granted cache.
REQ-011 SHALL have port m_read / m_write  output  1  shared downstream request, held until m_resp.
REQ-012 SHALL have port m_addr  output  ADDR_W  granted address, registered.
REQ-013 SHALL have port m_wdata  output  LINE_W  granted write data, registered.
REQ-014 SHALL have port m_rdata  input  LINE_W  downstream fill data, valid with m_resp.
REQ-015 SHALL have port m_resp  input  1  downstream one-cycle completion.
REQ-016 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-017 SHALL have port gnt_id  output  1  index of current or most recent grant.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-019 In IDLE with any request, SHALL grant one cache, latch its addr/wdata/op into registers, and enter BUSY.
REQ-020 SHALL assert m_read or m_write on the first BUSY cycle, one cycle after the request is sampled.
REQ-021 SHALL hold m_read/m_write/m_addr/m_wdata constant throughout BUSY.
REQ-022 On m_resp in BUSY, SHALL register m_rdata into c_rdata[gnt_id], deassert m_read/m_write the next cycle, and enter RESP.
REQ-023 In RESP, SHALL pulse c_resp[gnt_id] for exactly one cycle, keep the other c_resp low, then return to IDLE.
REQ-024 Minimum latency SHALL be: request sampled at cycle N, m_read at N+1, m_resp at N+1 gives c_resp at N+2.
REQ-025 SHALL ignore requests in BUSY and RESP; a requester drops its request the cycle after c_resp.
REQ-026 SHALL arbitrate round-robin using a 1-bit priority pointer. On simultaneous requests the pointer's cache wins.
REQ-027 SHALL set the pointer to the other cache when a grant completes in RESP.
REQ-028 A single requester SHALL be granted regardless of the pointer, with no idle bubble beyond RESP.
REQ-029 If c_read and c_write are both high for one cache, SHALL treat the request as a write; simulation SHALL flag an assertion error.
REQ-030 SHALL ignore m_resp in IDLE or RESP.
REQ-031 Back-to-back alternating requests SHALL each complete within one downstream transaction plus 2 cycles of the previous completion.

Reset
REQ-032 Asserting rst SHALL immediately force IDLE, pointer=0, gnt_id=0, busy=0, m_read=m_write=0, c_resp=0, m_addr=0, m_wdata=0, c_rdata=0.
REQ-033 Reset mid-BUSY SHALL abandon the transaction without a c_resp pulse; the downstream is reset by the same rst.
REQ-034 SHALL sample requests from the first rising edge after rst deasserts.

Structure
REQ-035 The FSM state enum typedef (dfp_arb_state_t) SHALL live in rv_pkg; ADDR_W/LINE_W defaults SHALL be rv_pkg constants.
REQ-036 The round-robin pick SHALL be a combinational sub-module rvtu_rr_pick2, with inputs req[2] and ptr and outputs gnt and gnt_id.

Verification
REQ-037 Single read: c_read[0]=1, c_addr[0]=0x40000010, m_resp 3 cycles later with m_rdata=0xDEADBEEF_...; m_addr=0x40000010 at N+1, c_resp[0] with same data, c_resp[1]=0.
REQ-038 Simultaneous: c_read[0]=c_write[1]=1 after reset: cache 0 granted first, then cache 1's write with m_wdata=c_wdata[1]; pointer=0 after both.
REQ-039 Fairness: both caches request continuously for 8 transactions: grants alternate 0,1,0,1,... and no cache waits more than one transaction.
REQ-040 Reset mid-BUSY: rst low two cycles after m_read: all outputs 0 that cycle, no c_resp; a new c_read[1] after release is served normally.
REQ-041 Spurious: m_resp pulsed in IDLE: no c_resp, state stays IDLE, busy=0.
REQ-042 Zero-wait downstream: m_resp in the first BUSY cycle: c_resp one cycle later and next pending request issued two cycles after that m_resp.
